// File: rtl/mem_pkg.sv
// Shared definitions for the byte-enabled data memory: access size codes,
// controller state encoding and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    // Halves must sit on even byte addresses, words on multiples of four.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return ((size == SZ_HALF) && lane[0]) ||
               ((size == SZ_WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// Load path: pick the addressed lane(s) out of a 32-bit word, right-justify
// them and sign- or zero-extend to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{lane, 3'b000} +: 8];
    assign half_v = lane[1] ? word[31:16] : word[15:0];

    // Extend the selected field; reserved size yields zero (it faults anyway).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        data = '0;
        unique case (size)
            SZ_BYTE: data = {{24{~uns & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{~uns & half_v[15]}}, half_v};
            SZ_WORD: data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_be.sv
// Single-port 32-bit data memory with byte/half/word access, sign/zero
// extended loads, fault detection and an optional zero-fill after reset.
module data_mem_be
    import mem_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rd,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [31:0]   rd_q, rd_d;

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [31:0]   ld_data;
    logic          fault;
    logic          accept;

    logic [3:0]    be;
    logic [31:0]   st_data;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_word;

    assign idx      = a[AW+1:2];
    assign lane     = a[1:0];
    assign cur_word = mem_q[idx];
    assign fault    = (size == SZ_RSVD) || misaligned(size, lane) || (|a[31:AW+2]);
    assign accept   = req && ready_q;

    assign ready    = ready_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;
    assign rd       = rd_q;

    load_align u_load_align (
        .word (cur_word),
        .size (size),
        .lane (lane),
        .uns  (uns),
        .data (ld_data)
    );

    // State and output registers; reset forces the idle-output values.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rd_q     <= rd_d;
        end
    end

    // Next state: walk the clear counter across every word, then go idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready tracks the upcoming state, completions follow an accept.
    always_comb begin
        ready_d  = (state_d == IDLE);
        rvalid_d = accept;
        err_d    = accept && fault;
        rd_d     = rd_q;
        if (accept && !we) begin
            rd_d = fault ? 32'h0 : ld_data;
        end
    end

    // Store lane merge, plus the clear-walk write port selection.
    always_comb begin
        be      = 4'b0000;
        st_data = wd;
        unique case (size)
            SZ_BYTE: begin be = 4'b0001 << lane;                 st_data = {4{wd[7:0]}};  end
            SZ_HALF: begin be = lane[1] ? 4'b1100 : 4'b0011;     st_data = {2{wd[15:0]}}; end
            SZ_WORD: begin be = 4'b1111;                         st_data = wd;            end
            default: begin be = 4'b0000;                         st_data = wd;            end
        endcase

        wr_word = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = st_data[8*i +: 8];
        end

        wr_idx = idx;
        wr_en  = accept && we && !fault && !reset;
        if (state_q == CLEAR) begin
            wr_idx  = cnt_q;
            wr_word = '0;
            wr_en   = !reset;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array itself is never reset; zero-fill is done by the clear walk when enabled.
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_data_mem_be.sv
// Directed self-checking bench for data_mem_be: a vector table for the
// load/store datapath plus hand sequences for reset and pipelining corners.
module tb_data_mem_be;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1, reset2 = 1'b1;
    logic        req = 1'b0, req2 = 1'b0;
    logic        we = 1'b0, uns = 1'b0;
    logic [1:0]  size = SZ_WORD;
    logic [31:0] a = '0, wd = '0;
    logic        ready, rvalid, err, ready2, rvalid2, err2;
    logic [31:0] rd, rd2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    data_mem_be #(.DEPTH(64), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .ready(ready), .rvalid(rvalid), .rd(rd), .err(err)
    );

    data_mem_be #(.DEPTH(16), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .reset(reset2), .req(req2), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .ready(ready2), .rvalid(rvalid2), .rd(rd2), .err(err2)
    );

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;   // expected load data (ignored for stores)
        logic        err;
    } vec_t;

    localparam int NV = 24;
    vec_t v [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One access: drive at a negedge, accepted at the next posedge, and return
    // at the following negedge where the completion is visible.
    task automatic access(input bit d2, input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = w; size = s; uns = u; a = addr; wd = data;
        if (d2) req2 = 1'b1; else req = 1'b1;
        @(negedge clk);
        req = 1'b0; req2 = 1'b0;
    endtask

    task automatic count_clear(output int n);
        n = 0;
        while (!ready && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [31:0] last_rd;
    logic [31:0] exp_rd;
    int          n;

    initial begin
        v[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0};
        v[1]  = '{1'b1, SZ_WORD, 1'b0, 32'h08, 32'h8000FF7F, 32'h0,        1'b0};
        v[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h08, 32'h0,        32'h0000007F, 1'b0};
        v[3]  = '{1'b0, SZ_BYTE, 1'b0, 32'h09, 32'h0,        32'hFFFFFFFF, 1'b0};
        v[4]  = '{1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0,        32'h000000FF, 1'b0};
        v[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0,        32'hFFFF8000, 1'b0};
        v[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0,        32'h00008000, 1'b0};
        v[7]  = '{1'b1, SZ_WORD, 1'b0, 32'h08, 32'h11223344, 32'h0,        1'b0};
        v[8]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0A, 32'hFFFFFFAB, 32'h0,        1'b0};
        v[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0,        32'h11AB3344, 1'b0};
        v[10] = '{1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0,        32'h000011AB, 1'b0};
        v[11] = '{1'b1, SZ_WORD, 1'b0, 32'h04, 32'hCAFEBABE, 32'h0,        1'b0};
        v[12] = '{1'b1, SZ_HALF, 1'b0, 32'h05, 32'h00001234, 32'h0,        1'b1};
        v[13] = '{1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0,        32'hCAFEBABE, 1'b0};
        v[14] = '{1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0,       32'h00000000, 1'b1};
        v[15] = '{1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0,        32'h00000000, 1'b1};
        v[16] = '{1'b0, SZ_RSVD, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b1};
        v[17] = '{1'b1, SZ_HALF, 1'b0, 32'h06, 32'hFFFFBEEF, 32'h0,        1'b0};
        v[18] = '{1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0,        32'hBEEFBABE, 1'b0};
        v[19] = '{1'b1, SZ_WORD, 1'b0, 32'hFC, 32'hDEADBEEF, 32'h0,        1'b0};
        v[20] = '{1'b0, SZ_BYTE, 1'b1, 32'hFF, 32'h0,        32'h000000DE, 1'b0};
        v[21] = '{1'b0, SZ_HALF, 1'b0, 32'hFE, 32'h0,        32'hFFFFDEAD, 1'b0};
        v[22] = '{1'b1, SZ_RSVD, 1'b0, 32'h00, 32'h77777777, 32'h0,        1'b1};
        v[23] = '{1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0,        32'h00000000, 1'b0};

        // Reset state, then the 64-cycle clear.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready",  ready,  0);
        check("reset rvalid", rvalid, 0);
        check("reset err",    err,    0);
        check("reset rd",     rd,     0);
        check("reset2 ready", ready2, 0);
        reset = 1'b0;
        count_clear(n);
        check("clear cycles", n, 64);

        // Datapath vector table.
        last_rd = 32'h0;
        for (int i = 0; i < NV; i++) begin
            access(1'b0, v[i].we, v[i].sz, v[i].uns, v[i].a, v[i].wd);
            exp_rd = v[i].we ? last_rd : v[i].rd;
            check($sformatf("v%0d rvalid", i), rvalid, 1);
            check($sformatf("v%0d err", i),    err,    v[i].err);
            check($sformatf("v%0d rd", i),     rd,     exp_rd);
            last_rd = exp_rd;
        end

        // Back-to-back store then load of the same word.
        @(negedge clk);
        we = 1'b1; size = SZ_WORD; uns = 1'b0; a = 32'h10; wd = 32'h12345678; req = 1'b1;
        @(negedge clk);
        we = 1'b0; wd = 32'h0;
        check("b2b store rvalid", rvalid, 1);
        check("b2b store err",    err,    0);
        check("b2b store rd",     rd,     last_rd);
        check("b2b ready",        ready,  1);
        @(negedge clk);
        req = 1'b0;
        check("b2b load rvalid", rvalid, 1);
        check("b2b load rd",     rd,     32'h12345678);
        @(negedge clk);
        check("pulse end rvalid", rvalid, 0);
        check("pulse end err",    err,    0);
        check("rd hold",          rd,     32'h12345678);

        // Ignored request while not ready, then reset restart mid-clear.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        we = 1'b0; size = SZ_WORD; a = 32'h10; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("busy req rvalid", rvalid, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid-clear ready", ready, 0);
        reset = 1'b0;
        count_clear(n);
        check("restart clear cycles", n, 64);
        access(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        check("cleared word rd", rd, 32'h0);
        access(1'b0, 1'b0, SZ_WORD, 1'b0, 32'hFC, 32'h0);
        check("cleared last rd", rd, 32'h0);

        // No-clear instance: immediate ready, contents survive reset,
        // and an access coinciding with reset is dropped.
        @(negedge clk);
        reset2 = 1'b0;
        @(negedge clk);
        check("nc ready", ready2, 1);
        access(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h00, 32'hA5A5A5A5);
        check("nc store rvalid", rvalid2, 1);
        access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0);
        check("nc load rd", rd2, 32'hA5A5A5A5);
        @(negedge clk);
        we = 1'b1; size = SZ_WORD; a = 32'h00; wd = 32'h11111111; req2 = 1'b1; reset2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0; reset2 = 1'b0;
        check("nc rst rvalid", rvalid2, 0);
        check("nc rst rd",     rd2,     0);
        check("nc rst ready",  ready2,  0);
        @(negedge clk);
        check("nc ready again", ready2, 1);
        access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0);
        check("nc kept rd", rd2, 32'hA5A5A5A5);
        access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
        check("nc range err", err2, 1);
        check("nc range rd",  rd2,  0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
